multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have parameter FUNC_W, default 6, function field width (passed to ALU decode, not used by FSM).
REQ-003 SHALL have parameter MEM_WAIT_EN, default 0; 1 = memory states wait for mem_ready, 0 = mem_ready ignored, single-cycle memory.
REQ-004 SHALL have ports: clk in 1 system clock; rst in 1 reset, asynchronous, active-high.
REQ-005 SHALL have inputs: opcode in OPCODE_W instruction opcode (from IR); zero in 1 ALU zero flag; mem_ready in 1 memory access complete.
REQ-006 SHALL have outputs (1 bit): pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, R31 (write-address select = 31), instr_done (one-cycle pulse per retired instruction), illegal_op (sticky).
REQ-007 SHALL have outputs (2 bits): alu_src_b (00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2); alu_op (00 add, 01 sub, 10 by func, 11 slt); pc_source (00 ALU result, 01 ALUOut, 10 jump target, 11 register rs).
REQ-008 SHALL have output state_dbg, 4 bits, current state encoding.

Function
REQ-009 SHALL be a Moore FSM; all control outputs decoded from state only, except pc_write_cond (Moore) which the datapath ANDs with zero.
REQ-010 SHALL implement states: IF, ID, MEM_ADDR, MEM_RD, WB_LW, MEM_WR, EX_R, WB_R, EX_I, WB_I, BR, JMP, JR, JAL.
REQ-011 IF: mem_read=1, i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1; next ID.
REQ-012 ID: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut); next by opcode: 100011/101011->MEM_ADDR, 000000->EX_R, 001001/001010->EX_I, 000100->BR, 000010->JMP, 000110->JR, 000011->JAL.
REQ-013 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_RD, sw->MEM_WR.
REQ-014 MEM_RD: mem_read=1, i_or_d=1; next WB_LW. WB_LW: reg_write=1, mem_to_reg=1, reg_dst=0; next IF.
REQ-015 MEM_WR: mem_write=1, i_or_d=1; next IF.
REQ-016 EX_R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB_R. WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; next IF.
REQ-017 EX_I: alu_src_a=1, alu_src_b=10, alu_op=00 for 001001, 11 for 001010; next WB_I. WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; next IF.
REQ-018 BR: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next IF.
REQ-019 JMP: pc_write=1, pc_source=10; next IF. JR: pc_write=1, pc_source=11; next IF.
REQ-020 JAL: pc_write=1, pc_source=10, reg_write=1, R31=1, mem_to_reg=0 (datapath writes PC+4); next IF.
REQ-021 EX_I latches no opcode; alu_op in EX_I decoded from the held IR opcode.
REQ-022 With MEM_WAIT_EN=1, IF, MEM_RD and MEM_WR SHALL hold state while mem_ready=0; in IF, ir_write and pc_write asserted only in the cycle mem_ready=1; mem_read/mem_write held throughout the wait.
REQ-023 instr_done SHALL pulse 1 in the last state of each instruction (WB_LW, MEM_WR on exit, WB_R, WB_I, BR, JMP, JR, JAL), coincident with the transition to IF.
REQ-024 Unrecognised opcode in ID SHALL set illegal_op=1 (sticky), assert instr_done, and return to IF (executed as NOP).
REQ-025 Latency: R/addi/slti 4 cycles, lw 5, sw 4, beq 3, j/jr/jal 3 (MEM_WAIT_EN=0).
REQ-026 All output bits not listed for a state SHALL be 0.

Reset
REQ-027 rst=1 SHALL asynchronously force state IF, illegal_op=0, and force every output to 0 while held, including mid-instruction.
REQ-028 First rising clk edge after rst deasserts SHALL execute IF normally.

Structure
REQ-029 Opcode constants, state encodings, alu_op/alu_src_b/pc_source encodings SHALL live in shared package mips_mc_pkg.
REQ-030 Next-state/output decode SHALL be a single module; alu_controller reused unchanged downstream, no other sub-module.

Verification
REQ-031 lw (100011), MEM_WAIT_EN=0 -> states IF,ID,MEM_ADDR,MEM_RD,WB_LW; reg_write=1 mem_to_reg=1 only in WB_LW; instr_done at cycle 5.
REQ-032 beq, zero=1 then zero=0 -> 3 cycles each; pc_write_cond=1 pc_source=01 in BR both times.
REQ-033 jal (000011) -> JAL state: R31=1 reg_write=1 pc_write=1 pc_source=10.
REQ-034 MEM_WAIT_EN=1, mem_ready held 0 for 3 cycles in IF -> state IF 4 cycles, ir_write=1 only in final cycle.
REQ-035 Opcode 111111 -> illegal_op=1 from cycle 3, FSM back in IF; stays 1 until rst.
REQ-036 rst asserted in MEM_WR -> mem_write drops to 0 same cycle without clock; state_dbg=IF.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// ALU/mux select codes and the packed control-word payload.
package mips_mc_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_JR    = 6'b000110;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_SLT  = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_LW    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EX_R     = 4'd6,
    S_WB_R     = 4'd7,
    S_EX_I     = 4'd8,
    S_WB_I     = 4'd9,
    S_BR       = 4'd10,
    S_JMP      = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       r31;
    logic       instr_done;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // State entered after ID; S_IF marks an unrecognised opcode.
  function automatic state_t id_next(input logic [OP_W-1:0] op);
    case (op)
      OP_LW, OP_SW:      return S_MEM_ADDR;
      OP_RTYPE:          return S_EX_R;
      OP_ADDI, OP_SLTI:  return S_EX_I;
      OP_BEQ:            return S_BR;
      OP_J:              return S_JMP;
      OP_JR:             return S_JR;
      OP_JAL:            return S_JAL;
      default:           return S_IF;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for a multi-cycle MIPS datapath.
// Ports: clk, rst (async active-high); opcode (held IR opcode), zero (ALU flag,
// consumed by the datapath together with pc_write_cond), mem_ready (memory
// handshake, honoured only when MEM_WAIT_EN=1). Outputs: datapath strobes and
// mux selects, instr_done (retire pulse), illegal_op (sticky), state_dbg.
module multi_cycle_controller
  import mips_mc_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned FUNC_W      = 6,
  parameter int unsigned MEM_WAIT_EN = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic                R31,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic [3:0]          state_dbg
);

  // FUNC_W belongs to the downstream ALU decoder; zero is gated in the datapath.
  localparam int unsigned unused_func_w = FUNC_W;
  logic unused_zero;
  assign unused_zero = zero;

  state_t          state, state_nxt;
  ctrl_t           ctrl, ctrl_out;
  logic            illegal_q, illegal_set;
  logic [OP_W-1:0] op6;
  state_t          id_tgt;
  logic            op_legal;
  logic            mem_done;

  // Opcode classification; wider opcode fields must carry zeros above bit 5.
  always_comb begin
    op6      = OP_W'(opcode);
    id_tgt   = id_next(op6);
    op_legal = (id_tgt != S_IF) && (OPCODE_W'(op6) == opcode);
  end

  assign mem_done = (MEM_WAIT_EN == 0) || mem_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_nxt;
  end

  // Sticky illegal-opcode flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              illegal_q <= 1'b0;
    else if (illegal_set) illegal_q <= 1'b1;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt   = state;
    ctrl        = '0;
    illegal_set = 1'b0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        // IR and PC commit only on the cycle the fetch completes.
        if (mem_done) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_nxt     = S_ID;
        end
      end
      S_ID: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        if (op_legal) begin
          state_nxt = id_tgt;
        end else begin
          // Unknown opcode retires as a NOP.
          illegal_set     = 1'b1;
          ctrl.instr_done = 1'b1;
          state_nxt       = S_IF;
        end
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_nxt      = (op6 == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_done) state_nxt = S_WB_LW;
      end
      S_WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_IF;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_done) begin
          ctrl.instr_done = 1'b1;
          state_nxt       = S_IF;
        end
      end
      S_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNC;
        state_nxt      = S_WB_R;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_IF;
      end
      S_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (op6 == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_nxt      = S_WB_I;
      end
      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_IF;
      end
      S_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.instr_done    = 1'b1;
        state_nxt          = S_IF;
      end
      S_JMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_JUMP;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_IF;
      end
      S_JR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_RS;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_IF;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.r31        = 1'b1;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
  end

  // Reset silences every strobe immediately, even mid-instruction.
  assign ctrl_out = rst ? '0 : ctrl;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign i_or_d        = ctrl_out.i_or_d;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign R31           = ctrl_out.r31;
  assign instr_done    = ctrl_out.instr_done;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign pc_source     = ctrl_out.pc_source;
  assign illegal_op    = illegal_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: a single-cycle-memory
// instance driven through a per-cycle expectation queue, plus a wait-state
// instance exercised with a mem_ready stimulus table.
module tb_multi_cycle_controller;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rst1, zero, mem_ready0, mem_ready1;
  logic [5:0] opcode;

  logic pw0, pwc0, iod0, irw0, mr0, mw0, m2r0, rd0, rw0, asa0, r310, done0, ill0;
  logic [1:0] asb0, aop0, ps0;
  logic [3:0] st0;
  logic pw1, pwc1, iod1, irw1, mr1, mw1, m2r1, rd1, rw1, asa1, r311, done1, ill1;
  logic [1:0] asb1, aop1, ps1;
  logic [3:0] st1;

  logic [17:0] obs0, obs1;
  assign obs0 = {pw0, pwc0, iod0, irw0, mr0, mw0, m2r0, rd0, rw0, asa0, r310, done0, asb0, aop0, ps0};
  assign obs1 = {pw1, pwc1, iod1, irw1, mr1, mw1, m2r1, rd1, rw1, asa1, r311, done1, asb1, aop1, ps1};

  multi_cycle_controller #(.OPCODE_W(6), .FUNC_W(6), .MEM_WAIT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready0),
    .pc_write(pw0), .pc_write_cond(pwc0), .i_or_d(iod0), .ir_write(irw0),
    .mem_read(mr0), .mem_write(mw0), .mem_to_reg(m2r0), .reg_dst(rd0),
    .reg_write(rw0), .alu_src_a(asa0), .R31(r310), .instr_done(done0),
    .illegal_op(ill0), .alu_src_b(asb0), .alu_op(aop0), .pc_source(ps0),
    .state_dbg(st0)
  );

  multi_cycle_controller #(.OPCODE_W(6), .FUNC_W(6), .MEM_WAIT_EN(1)) dut1 (
    .clk(clk), .rst(rst1), .opcode(opcode), .zero(zero), .mem_ready(mem_ready1),
    .pc_write(pw1), .pc_write_cond(pwc1), .i_or_d(iod1), .ir_write(irw1),
    .mem_read(mr1), .mem_write(mw1), .mem_to_reg(m2r1), .reg_dst(rd1),
    .reg_write(rw1), .alu_src_a(asa1), .R31(r311), .instr_done(done1),
    .illegal_op(ill1), .alu_src_b(asb1), .alu_op(aop1), .pc_source(ps1),
    .state_dbg(st1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_ill;

  logic [5:0] legal_ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b001001,
                                6'b001010, 6'b000100, 6'b000010, 6'b000110, 6'b000011};

  function automatic logic is_legal(input logic [5:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference control word per state, bit order matching obs0.
  function automatic logic [17:0] exp_ctrl(input state_t s, input logic [5:0] op);
    logic pw, pwc, iod, irw, mr, mw, m2r, rd, rw, asa, r31, dn;
    logic [1:0] asb, aop, ps;
    {pw, pwc, iod, irw, mr, mw, m2r, rd, rw, asa, r31, dn, asb, aop, ps} = 18'd0;
    case (s)
      S_IF:       begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      S_ID:       begin asb = 2'b11; dn = !is_legal(op); end
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mr = 1; iod = 1; end
      S_WB_LW:    begin rw = 1; m2r = 1; dn = 1; end
      S_MEM_WR:   begin mw = 1; iod = 1; dn = 1; end
      S_EX_R:     begin asa = 1; aop = 2'b10; end
      S_WB_R:     begin rw = 1; rd = 1; dn = 1; end
      S_EX_I:     begin asa = 1; asb = 2'b10; aop = (op == 6'b001010) ? 2'b11 : 2'b00; end
      S_WB_I:     begin rw = 1; dn = 1; end
      S_BR:       begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      S_JMP:      begin pw = 1; ps = 2'b10; dn = 1; end
      S_JR:       begin pw = 1; ps = 2'b11; dn = 1; end
      S_JAL:      begin pw = 1; ps = 2'b10; rw = 1; r31 = 1; dn = 1; end
      default:    ;
    endcase
    return {pw, pwc, iod, irw, mr, mw, m2r, rd, rw, asa, r31, dn, asb, aop, ps};
  endfunction

  // Consumer: one expectation popped and compared per cycle on dut0.
  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (st0 !== e.st) begin
          errors++;
          $display("FAIL sb_state op=%b got %0d expected %0d", opcode, st0, e.st);
        end
        checks++;
        if (obs0 !== e.ctrl) begin
          errors++;
          $display("FAIL sb_ctrl op=%b state=%0d got %h expected %h", opcode, e.st, obs0, e.ctrl);
        end
        checks++;
        if (ill0 !== e.ill) begin
          errors++;
          $display("FAIL sb_illegal op=%b state=%0d got %b expected %b", opcode, e.st, ill0, e.ill);
        end
      end
    end
  endtask

  // Producer: drives one instruction on dut0, pushing one expectation per cycle.
  // Entered and left just after a rising edge with dut0 in IF.
  task automatic exec(input logic [5:0] op, input logic z);
    state_t path[$];
    exp_t   e;
    path.push_back(S_IF);
    path.push_back(S_ID);
    case (op)
      6'b100011: begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_RD); path.push_back(S_WB_LW); end
      6'b101011: begin path.push_back(S_MEM_ADDR); path.push_back(S_MEM_WR); end
      6'b000000: begin path.push_back(S_EX_R); path.push_back(S_WB_R); end
      6'b001001,
      6'b001010: begin path.push_back(S_EX_I); path.push_back(S_WB_I); end
      6'b000100: path.push_back(S_BR);
      6'b000010: path.push_back(S_JMP);
      6'b000110: path.push_back(S_JR);
      6'b000011: path.push_back(S_JAL);
      default:   ;
    endcase
    foreach (path[i]) begin
      opcode = op;
      zero   = z;
      e.st   = path[i];
      e.ctrl = exp_ctrl(path[i], op);
      e.ill  = exp_ill;
      sb_q.push_back(e);
      if (path[i] == S_ID && !is_legal(op)) exp_ill = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1; opcode = 6'b100011; zero = 1'b0;
    mem_ready0 = 1'b0; mem_ready1 = 1'b0; exp_ill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({st0, obs0, ill0} !== 23'd0) begin
      errors++;
      $display("FAIL reset_dut0 got %h expected 0", {st0, obs0, ill0});
    end
    checks++;
    if ({st1, obs1, ill1} !== 23'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %h expected 0", {st1, obs1, ill1});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    exec(6'b100011, 1'b0);
    checks++;
    if (st0 !== 4'(S_IF)) begin errors++; $display("FAIL lw_return got %0d expected 0", st0); end
  endtask

  task automatic test_sw();
    exec(6'b101011, 1'b1);
  endtask

  task automatic test_alu_ops();
    exec(6'b000000, 1'b0);
    exec(6'b000000, 1'b1);
    exec(6'b001001, 1'b0);
    exec(6'b001010, 1'b1);
  endtask

  task automatic test_beq();
    exec(6'b000100, 1'b1);
    exec(6'b000100, 1'b0);
    checks++;
    if (st0 !== 4'(S_IF)) begin errors++; $display("FAIL beq_return got %0d expected 0", st0); end
  endtask

  task automatic test_jumps();
    exec(6'b000010, 1'b0);
    exec(6'b000110, 1'b0);
    exec(6'b000011, 1'b1);
  endtask

  task automatic test_illegal();
    exec(6'b111111, 1'b0);
    checks++;
    if ({st0, ill0} !== {4'(S_IF), 1'b1}) begin
      errors++;
      $display("FAIL illegal_set got state=%0d ill=%b expected state=0 ill=1", st0, ill0);
    end
    exec(6'b001001, 1'b0);
    exec(6'b000001, 1'b1);
    checks++;
    if (ill0 !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b expected 1", ill0); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    for (int n = 0; n < 12; n++) begin
      op = legal_ops[$urandom_range(0, 8)];
      exec(op, 1'($urandom_range(0, 1)));
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain got %0d expected 0", sb_q.size()); end
  endtask

  // Wait-state instance: {state, pc_write, ir_write, mem_read, mem_write, instr_done}.
  task automatic test_mem_wait();
    state_t     w_st  [15] = '{S_IF, S_IF, S_IF, S_IF, S_ID, S_MEM_ADDR, S_MEM_RD, S_MEM_RD,
                               S_WB_LW, S_IF, S_ID, S_MEM_ADDR, S_MEM_WR, S_MEM_WR, S_IF};
    logic       w_rdy [15] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    logic [4:0] w_exp [15] = '{5'b00100, 5'b00100, 5'b00100, 5'b11100, 5'b00000, 5'b00000,
                               5'b00100, 5'b00100, 5'b00001, 5'b11100, 5'b00000, 5'b00000,
                               5'b00010, 5'b00011, 5'b00100};
    rst1 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mem_ready1 = w_rdy[i];
      opcode     = (i < 9) ? 6'b100011 : 6'b101011;
      @(negedge clk);
      checks++;
      if ({st1, pw1, irw1, mr1, mw1, done1} !== {4'(w_st[i]), w_exp[i]}) begin
        errors++;
        $display("FAIL mem_wait step=%0d got %h expected %h", i,
                 {st1, pw1, irw1, mr1, mw1, done1}, {4'(w_st[i]), w_exp[i]});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (ill0 !== 1'b1) begin errors++; $display("FAIL illegal_hold got %b expected 1", ill0); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ill0 !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b expected 0", ill0); end
    rst = 1'b0; exp_ill = 1'b0; opcode = 6'b101011; zero = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({st0, mw0} !== {4'(S_MEM_WR), 1'b1}) begin
      errors++;
      $display("FAIL mid_pre got state=%0d mw=%b expected state=5 mw=1", st0, mw0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mw0 !== 1'b0) begin errors++; $display("FAIL mid_mem_write got %b expected 0", mw0); end
    checks++;
    if (st0 !== 4'(S_IF)) begin errors++; $display("FAIL mid_state got %0d expected 0", st0); end
    checks++;
    if ({obs0, ill0} !== 19'd0) begin errors++; $display("FAIL mid_outputs got %h expected 0", {obs0, ill0}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_lw();
    test_sw();
    test_alu_ops();
    test_beq();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_mem_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
